// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, XZR index, opcode constants used for
// register-select decoding, and the IF/ID pipeline record.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int INSTR_W_DEF = 32;

  // Encoding loaded into IF/ID on reset and on a squash
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  // Register 31 reads as zero; it never creates a dependency
  localparam logic [4:0] XZR_IDX = 5'd31;

  // Opcodes whose second read port selects Rt ([4:0]) instead of Rm ([20:16])
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [ADDR_W_DEF-1:0]  next_pc;
    logic [INSTR_W_DEF-1:0] instr;
    logic                   valid;
  } if_id_t;

  // reg2loc: second source register comes from the Rt field
  function automatic logic reg2loc_f(input logic [31:0] instr);
    return (instr[31:21] == OP_STUR) || (instr[31:24] == OP_CBZ);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector. Compares the destination of a load
// currently in EX against both source registers of the instruction in ID.
// Shared with the ID/EX forwarding logic.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic [31:0] i_id_instr,
  input  logic        i_id_valid,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rd,
  output logic        o_lu_hz
);

  logic [4:0] w_rn;
  logic [4:0] w_rm_sel;
  logic       w_reg2loc;
  logic       w_rd_live;

  // Decode source register fields and evaluate the hazard condition
  always_comb begin
    w_rn      = i_id_instr[9:5];
    w_reg2loc = reg2loc_f(i_id_instr);
    if (w_reg2loc) begin
      w_rm_sel = i_id_instr[4:0];
    end else begin
      w_rm_sel = i_id_instr[20:16];
    end
    w_rd_live = (i_ex_rd != XZR_IDX);
    o_lu_hz   = i_id_valid & i_ex_mem_read & w_rd_live &
                ((i_ex_rd == w_rn) | (i_ex_rd == w_rm_sel));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, squash on taken
// branch and fetch PC write-enable / ID bubble generation.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN;
// without it stall_count and flush_count read as zero and carry no flops.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          INSTR_W   = INSTR_W_DEF,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [ADDR_W-1:0]  if_next_pc,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               flush,
  input  logic               ext_stall,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rd,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_next_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid,
  output logic               pc_write_en,
  output logic               id_bubble,
  output logic [31:0]        stall_count,
  output logic [31:0]        flush_count
);

  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_next_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  logic w_lu_hz;
  logic w_stall;

  load_use_detect u_load_use_detect (
    .i_id_instr    (r_instr[31:0]),
    .i_id_valid    (r_valid),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd       (ex_rd),
    .o_lu_hz       (w_lu_hz)
  );

  // Stall / fetch-enable / bubble controls; a flush always lets fetch advance
  always_comb begin
    w_stall     = w_lu_hz | ext_stall;
    pc_write_en = ~w_stall | flush;
    id_bubble   = w_lu_hz & ~flush;
  end

  // Pipeline register update: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_next_pc <= '0;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
    end else if (flush) begin
      r_pc      <= if_pc;
      r_next_pc <= if_next_pc;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
    end else if (w_stall) begin
      r_pc      <= r_pc;
      r_next_pc <= r_next_pc;
      r_instr   <= r_instr;
      r_valid   <= r_valid;
    end else begin
      r_pc      <= if_pc;
      r_next_pc <= if_next_pc;
      r_instr   <= if_instr;
      r_valid   <= 1'b1;
    end
  end

  assign id_pc      = r_pc;
  assign id_next_pc = r_next_pc;
  assign id_instr   = r_instr;
  assign id_valid   = r_valid;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating stall counter: counts stalled cycles not overridden by a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && !flush && (r_stall_cnt != 32'hFFFFFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Saturating flush counter: counts every squash cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= 32'd0;
    end else if (flush && (r_flush_cnt != 32'hFFFFFFFF)) begin
      r_flush_cnt <= r_flush_cnt + 32'd1;
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_pc;
  logic [63:0] if_next_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        ext_stall;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [63:0] id_pc;
  logic [63:0] id_next_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        pc_write_en;
  logic        id_bubble;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP  = 32'hD503201F;
  localparam logic [31:0] ADD  = 32'h8B040023; // ADD X3,X1,X4: Rn=1 Rm=4
  localparam logic [31:0] STUR = 32'hF8000041; // STUR X1,[X2]: Rn=2 Rt=1, [20:16]=0

`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .if_next_pc  (if_next_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .ext_stall   (ext_stall),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_pc       (id_pc),
    .id_next_pc  (id_next_pc),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .pc_write_en (pc_write_en),
    .id_bubble   (id_bubble),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [63:0] pc, input logic [31:0] ins);
    if_pc      = pc;
    if_next_pc = pc + 64'd4;
    if_instr   = ins;
  endtask

  task automatic chk_id(input string tag, input logic [63:0] pc, input logic [31:0] ins, input logic v);
    chk({tag, "_pc"},    id_pc,      pc);
    chk({tag, "_npc"},   id_next_pc, pc + 64'd4);
    chk({tag, "_instr"}, {32'd0, id_instr}, {32'd0, ins});
    chk({tag, "_valid"}, {63'd0, id_valid}, {63'd0, v});
  endtask

  task automatic chk_ctl(input string tag, input logic pcwe, input logic bub);
    #1;
    chk({tag, "_pcwe"},   {63'd0, pc_write_en}, {63'd0, pcwe});
    chk({tag, "_bubble"}, {63'd0, id_bubble},   {63'd0, bub});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] s, input logic [31:0] f);
    chk({tag, "_stallcnt"}, {32'd0, stall_count}, {32'd0, (PERF ? s : 32'd0)});
    chk({tag, "_flushcnt"}, {32'd0, flush_count}, {32'd0, (PERF ? f : 32'd0)});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ext_stall = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    fetch(64'h10, ADD);
    step();
    chk("rst_pc", id_pc, 64'd0);
    chk("rst_npc", id_next_pc, 64'd0);
    chk("rst_instr", {32'd0, id_instr}, {32'd0, NOP});
    chk("rst_valid", {63'd0, id_valid}, 64'd0);
    chk_ctl("rst", 1'b1, 1'b0);
    chk_cnt("rst", 32'd0, 32'd0);

    // Plain load
    rst = 1'b0;
    step();
    chk_id("load_add", 64'h10, ADD, 1'b1);

    // Load to XZR never stalls
    ex_mem_read = 1'b1; ex_rd = 5'd31;
    chk_ctl("xzr", 1'b1, 1'b0);
    // Load to X1 matches Rn -> stall; X4 matches Rm
    ex_rd = 5'd4;
    chk_ctl("add_rm", 1'b0, 1'b1);
    ex_rd = 5'd3;
    chk_ctl("add_rd_nomatch", 1'b1, 1'b0);
    ex_rd = 5'd1;
    chk_ctl("add_rn", 1'b0, 1'b1);
    fetch(64'h20, STUR);
    step();                                   // stall cycle 1
    chk_id("held_add", 64'h10, ADD, 1'b1);
    ex_mem_read = 1'b0;
    chk_ctl("release", 1'b1, 1'b0);
    step();
    chk_id("load_stur", 64'h20, STUR, 1'b1);

    // STUR: second source comes from Rt=[4:0]
    ex_mem_read = 1'b1; ex_rd = 5'd4;
    chk_ctl("stur_r4", 1'b1, 1'b0);
    ex_rd = 5'd0;
    chk_ctl("stur_rm_field", 1'b1, 1'b0);
    ex_rd = 5'd2;
    chk_ctl("stur_rn", 1'b0, 1'b1);
    ex_rd = 5'd1;
    chk_ctl("stur_rt", 1'b0, 1'b1);
    fetch(64'h30, ADD);
    step();                                   // stall cycle 2
    chk_id("held_stur", 64'h20, STUR, 1'b1);

    // Flush together with a live hazard
    flush = 1'b1;
    chk_ctl("flush_hz", 1'b1, 1'b0);
    step();                                   // flush 1
    chk("flush_instr", {32'd0, id_instr}, {32'd0, NOP});
    chk("flush_valid", {63'd0, id_valid}, 64'd0);
    flush = 1'b0; ex_rd = 5'd0;               // NOP Rn field is 0
    chk_ctl("squashed_nohz", 1'b1, 1'b0);

    // Back-to-back flush
    flush = 1'b1;
    step();                                   // flush 2
    chk("flush2_valid", {63'd0, id_valid}, 64'd0);
    flush = 1'b0; ex_mem_read = 1'b0;
    fetch(64'h40, ADD);
    step();
    chk_id("load_after_flush", 64'h40, ADD, 1'b1);

    // External stall
    ext_stall = 1'b1;
    fetch(64'h50, STUR);
    chk_ctl("ext_stall", 1'b0, 1'b0);
    step();                                   // stall cycle 3
    chk_id("ext_held", 64'h40, ADD, 1'b1);
    chk_cnt("perf", 32'd3, 32'd2);

    // Reset while stalled
    rst = 1'b1;
    step();
    chk("rst2_valid", {63'd0, id_valid}, 64'd0);
    chk("rst2_instr", {32'd0, id_instr}, {32'd0, NOP});
    chk("rst2_pc", id_pc, 64'd0);
    chk_cnt("rst2", 32'd0, 32'd0);
    rst = 1'b0; ext_stall = 1'b0;
    chk_ctl("post_rst", 1'b1, 1'b0);
    step();
    chk_id("post_rst_load", 64'h50, STUR, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
